pll_lock_sequencer: RTL and testbench

//   Sequences the iCE40 48 MHz clock PLL and the AES core reset. Runs on the 12 MHz board reference clock, which keeps running while the PLL is unlocked.

---
 rtl/pll_lock_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Bring-up sequencer for the 48 MHz PLL and the AES core reset, clocked from the free-running 12 MHz reference.
// Pulses PLL RESETB, waits for lock with timeout/retry, qualifies lock stability, then releases the core.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1200,
    parameter int unsigned STABLE_CYCLES = 120,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       i_clock_in,
    input  logic       i_reset,
    input  logic       i_locked,
    input  logic       i_retry,
    output logic       o_pll_resetb,
    output logic       o_core_reset,
    output logic       o_ready,
    output logic       o_pll_fail,
    output logic       o_lock_lost,
    output logic [2:0] o_state,
    output logic [3:0] o_retry_count
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_retry_count;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic             r_pll_resetb;
    logic             r_core_reset;
    logic             r_ready;
    logic             r_pll_fail;
    logic             r_lock_lost;

    state_t           w_state_next;
    logic [3:0]       w_retry_next;
    logic             w_lock_lost_next;

    // LOCK comes from the PLL and is asynchronous to the reference clock.
    always_ff @(posedge i_clock_in or posedge i_reset) begin
        if (i_reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= i_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Lock status is tested ahead of any count expiry on the same edge.
    always_comb begin
        w_state_next     = ST_PLL_RST;
        w_retry_next     = r_retry_count;
        w_lock_lost_next = r_lock_lost;
        case (r_state)
            ST_PLL_RST: begin
                w_state_next = (r_cnt == RST_LAST) ? ST_WAIT_LOCK : ST_PLL_RST;
            end
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_next = ST_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    if (r_retry_count < RETRY_MAX) begin
                        w_retry_next = r_retry_count + 4'd1;
                        w_state_next = ST_PLL_RST;
                    end else begin
                        w_state_next = ST_FAIL;
                    end
                end else begin
                    w_state_next = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!r_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_STABLE;
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_next     = ST_PLL_RST;
                    w_lock_lost_next = 1'b1;
                    w_retry_next     = 4'd0;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FAIL: begin
                if (i_retry) begin
                    w_state_next = ST_PLL_RST;
                    w_retry_next = 4'd0;
                end else begin
                    w_state_next = ST_FAIL;
                end
            end
            default: begin
                w_state_next = ST_PLL_RST;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as r_state.
    always_ff @(posedge i_clock_in or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_PLL_RST;
            r_cnt         <= '0;
            r_retry_count <= 4'd0;
            r_pll_resetb  <= 1'b0;
            r_core_reset  <= 1'b1;
            r_ready       <= 1'b0;
            r_pll_fail    <= 1'b0;
            r_lock_lost   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_retry_count <= w_retry_next;
            r_lock_lost   <= w_lock_lost_next;
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (w_state_next)
                ST_WAIT_LOCK, ST_STABLE: begin
                    r_pll_resetb <= 1'b1;
                    r_core_reset <= 1'b1;
                    r_ready      <= 1'b0;
                    r_pll_fail   <= 1'b0;
                end
                ST_RUN: begin
                    r_pll_resetb <= 1'b1;
                    r_core_reset <= 1'b0;
                    r_ready      <= 1'b1;
                    r_pll_fail   <= 1'b0;
                end
                ST_FAIL: begin
                    r_pll_resetb <= 1'b0;
                    r_core_reset <= 1'b1;
                    r_ready      <= 1'b0;
                    r_pll_fail   <= 1'b1;
                end
                default: begin
                    r_pll_resetb <= 1'b0;
                    r_core_reset <= 1'b1;
                    r_ready      <= 1'b0;
                    r_pll_fail   <= 1'b0;
                end
            endcase
        end
    end

    assign o_pll_resetb  = r_pll_resetb;
    assign o_core_reset  = r_core_reset;
    assign o_ready       = r_ready;
    assign o_pll_fail    = r_pll_fail;
    assign o_lock_lost   = r_lock_lost;
    assign o_state       = r_state;
    assign o_retry_count = r_retry_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
// Expected output vectors are queued as each step is driven and popped when the DUT is sampled.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       retry;
    logic       pll_resetb;
    logic       core_reset;
    logic       ready;
    logic       pll_fail;
    logic       lock_lost;
    logic [2:0] state;
    logic [3:0] retry_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [11:0] v;
    } exp_t;

    exp_t sb_q[$];

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (16)
    ) dut (
        .i_clock_in   (clk),
        .i_reset      (rst),
        .i_locked     (locked),
        .i_retry      (retry),
        .o_pll_resetb (pll_resetb),
        .o_core_reset (core_reset),
        .o_ready      (ready),
        .o_pll_fail   (pll_fail),
        .o_lock_lost  (lock_lost),
        .o_state      (state),
        .o_retry_count(retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {state, pll_resetb, core_reset, ready, pll_fail, lock_lost, retry_count}
    function automatic logic [11:0] pk(input logic [2:0] st, input logic rb, input logic cr,
                                       input logic rdy, input logic fl, input logic ll,
                                       input logic [3:0] rc);
        return {st, rb, cr, rdy, fl, ll, rc};
    endfunction

    task automatic push(input string tag, input logic [11:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        logic [11:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = {state, pll_resetb, core_reset, ready, pll_fail, lock_lost, retry_count};
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b1;
        retry  = 1'b0;
        tick(3);
        push("reset_values", pk(3'd0, 0, 1, 0, 0, 0, 4'd0));
        chk();

        // Nominal lock; reset is released just after a rising edge, so tick(n) lands after edge n.
        rst = 1'b0;
        push("nom_e3_pll_rst", pk(3'd0, 0, 1, 0, 0, 0, 4'd0));
        tick(3); chk();
        push("nom_e4_resetb_rise", pk(3'd1, 1, 1, 0, 0, 0, 4'd0));
        tick(1); chk();
        push("nom_e5_stable", pk(3'd2, 1, 1, 0, 0, 0, 4'd0));
        tick(1); chk();
        push("nom_e12_still_stable", pk(3'd2, 1, 1, 0, 0, 0, 4'd0));
        tick(7); chk();
        push("nom_e13_run", pk(3'd3, 1, 0, 1, 0, 0, 4'd0));
        tick(1); chk();

        retry = 1'b1;
        push("retry_in_run_ignored", pk(3'd3, 1, 0, 1, 0, 0, 4'd0));
        tick(1); chk();
        retry = 1'b0;

        // Loss of lock in RUN: two synchroniser edges, then back to PLL_RST.
        locked = 1'b0;
        push("loss_sync_delay", pk(3'd3, 1, 0, 1, 0, 0, 4'd0));
        tick(2); chk();
        push("loss_to_pll_rst", pk(3'd0, 0, 1, 0, 0, 1, 4'd0));
        tick(1); chk();
        locked = 1'b1;
        push("relock_wait", pk(3'd1, 1, 1, 0, 0, 1, 4'd0));
        tick(4); chk();
        push("relock_stable", pk(3'd2, 1, 1, 0, 0, 1, 4'd0));
        tick(1); chk();
        push("relock_pre_run", pk(3'd2, 1, 1, 0, 0, 1, 4'd0));
        tick(7); chk();
        push("relock_run_sticky", pk(3'd3, 1, 0, 1, 0, 1, 4'd0));
        tick(1); chk();

        // Asynchronous reset mid-cycle in RUN.
        #3;
        rst = 1'b1;
        #1;
        push("async_reset_no_edge", pk(3'd0, 0, 1, 0, 0, 0, 4'd0));
        chk();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Glitch during STABLE at cnt=5.
        push("glitch_e10_stable", pk(3'd2, 1, 1, 0, 0, 0, 4'd0));
        tick(10); chk();
        locked = 1'b0;
        push("glitch_e12_stable", pk(3'd2, 1, 1, 0, 0, 0, 4'd0));
        tick(2); chk();
        push("glitch_beats_stable_cnt", pk(3'd1, 1, 1, 0, 0, 0, 4'd0));
        tick(1); chk();
        locked = 1'b1;
        retry  = 1'b1;
        push("retry_in_wait_ignored", pk(3'd1, 1, 1, 0, 0, 0, 4'd0));
        tick(1); chk();
        retry = 1'b0;
        push("glitch_e15_wait", pk(3'd1, 1, 1, 0, 0, 0, 4'd0));
        tick(1); chk();
        push("glitch_e16_stable", pk(3'd2, 1, 1, 0, 0, 0, 4'd0));
        tick(1); chk();
        push("glitch_e23_stable", pk(3'd2, 1, 1, 0, 0, 0, 4'd0));
        tick(7); chk();
        push("glitch_e24_run", pk(3'd3, 1, 0, 1, 0, 0, 4'd0));
        tick(1); chk();

        // No lock: two retries then FAIL.
        rst    = 1'b1;
        locked = 1'b0;
        tick(1);
        rst = 1'b0;
        push("nolock_e23_wait", pk(3'd1, 1, 1, 0, 0, 0, 4'd0));
        tick(23); chk();
        push("nolock_e24_timeout1", pk(3'd0, 0, 1, 0, 0, 0, 4'd1));
        tick(1); chk();
        push("nolock_e28_wait", pk(3'd1, 1, 1, 0, 0, 0, 4'd1));
        tick(4); chk();
        push("nolock_e48_timeout2", pk(3'd0, 0, 1, 0, 0, 0, 4'd2));
        tick(20); chk();
        push("nolock_e71_wait", pk(3'd1, 1, 1, 0, 0, 0, 4'd2));
        tick(23); chk();
        push("nolock_e72_fail", pk(3'd4, 0, 1, 0, 1, 0, 4'd2));
        tick(1); chk();

        // Recovery from FAIL via retry pulse.
        locked = 1'b1;
        push("fail_holds_with_lock", pk(3'd4, 0, 1, 0, 1, 0, 4'd2));
        tick(5); chk();
        retry = 1'b1;
        push("retry_to_pll_rst", pk(3'd0, 0, 1, 0, 0, 0, 4'd0));
        tick(1); chk();
        retry = 1'b0;
        push("recover_wait", pk(3'd1, 1, 1, 0, 0, 0, 4'd0));
        tick(4); chk();
        push("recover_stable", pk(3'd2, 1, 1, 0, 0, 0, 4'd0));
        tick(1); chk();
        push("recover_run", pk(3'd3, 1, 0, 1, 0, 0, 4'd0));
        tick(8); chk();

        checks++;
        assert (sb_q.size() === 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
